// File: rtl/cpu_mem_responder.sv
// Memory-side bus target for the 8-bit CPU: 256-byte program ROM plus a RAM window,
// with per-direction wait states, a one-cycle ready strobe and decode error reporting.
module cpu_mem_responder #(
    parameter int RAM_AW  = 10,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr_bus,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [7:0]  wr_data,
    output logic [7:0]  rd_data,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        busy,
    input  logic        prog_we,
    input  logic [7:0]  prog_addr,
    input  logic [7:0]  prog_data
);

    localparam logic [15:0] RAM_BASE = 16'h0100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic        r_is_wr;
    logic [3:0]  r_cnt;

    logic [7:0]  r_rom [256];
    logic [7:0]  r_ram [2**RAM_AW];

    logic        w_req_one;
    logic        w_req_both;
    logic [3:0]  w_load_cnt;
    logic [15:0] w_sel_addr;
    logic [7:0]  w_sel_wdata;
    logic        w_sel_wr;
    logic        w_commit;
    logic [15:0] w_ram_off;
    logic        w_in_rom;
    logic        w_in_ram;
    logic [7:0]  w_rd_byte;
    logic        w_err;

    // A zero-wait access commits on the sampling edge itself, so decode must see the
    // live bus in IDLE and the latched copy once the access is in flight.
    always_comb begin
        w_req_one   = mem_read ^ mem_write;
        w_req_both  = mem_read & mem_write;
        w_load_cnt  = mem_write ? 4'(WR_WAIT) : 4'(RD_WAIT);
        w_sel_addr  = (r_state == S_IDLE) ? addr_bus  : r_addr;
        w_sel_wdata = (r_state == S_IDLE) ? wr_data   : r_wdata;
        w_sel_wr    = (r_state == S_IDLE) ? mem_write : r_is_wr;
        w_commit    = !reset &&
                      (((r_state == S_IDLE) && w_req_one && (w_load_cnt == 4'd0)) ||
                       ((r_state == S_WAIT) && (r_cnt == 4'd1)));
        w_ram_off   = w_sel_addr - RAM_BASE;
        w_in_rom    = (w_sel_addr[15:8] == 8'h00);
        w_in_ram    = !w_in_rom && ((w_ram_off >> RAM_AW) == 16'd0);
        w_rd_byte   = 8'hFF;
        if (w_in_rom)
            w_rd_byte = r_rom[w_sel_addr[7:0]];
        else if (w_in_ram)
            w_rd_byte = r_ram[w_ram_off[RAM_AW-1:0]];
        w_err       = w_sel_wr ? !w_in_ram : !(w_in_rom || w_in_ram);
    end

    // NOTE: memory arrays carry no reset; contents survive reset and map to plain RAM.
    always_ff @(posedge clk) begin
        if (prog_we)
            r_rom[prog_addr] <= prog_data;
        if (w_commit && w_sel_wr && w_in_ram)
            r_ram[w_ram_off[RAM_AW-1:0]] <= w_sel_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_addr    <= 16'h0000;
            r_wdata   <= 8'h00;
            r_is_wr   <= 1'b0;
            r_cnt     <= 4'd0;
            rd_data   <= 8'h00;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            if (w_commit) begin
                mem_ready <= 1'b1;
                mem_err   <= w_err;
                if (!w_sel_wr)
                    rd_data <= w_rd_byte;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_req_both) begin
                        // Conflicting request: report it without touching memory.
                        r_state   <= S_DONE;
                        mem_ready <= 1'b1;
                        mem_err   <= 1'b1;
                        busy      <= 1'b1;
                    end else if (w_req_one) begin
                        r_addr  <= addr_bus;
                        r_wdata <= wr_data;
                        r_is_wr <= mem_write;
                        r_cnt   <= w_load_cnt;
                        busy    <= 1'b1;
                        r_state <= (w_load_cnt == 4'd0) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: the driver queues expected responses,
// an independent monitor checks them whenever mem_ready strobes.
module tb_cpu_mem_responder;

    localparam int RD_W = 1;
    localparam int WR_W = 0;
    localparam int RD   = 0;
    localparam int WR   = 1;
    localparam int BOTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr_bus;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        mem_ready;
    logic        mem_err;
    logic        busy;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [7:0]  prog_data;

    typedef struct {
        string      name;
        logic [7:0] rd;
        bit         chk_rd;
        bit         err;
        int         rdy_cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    bit         after_ready = 1'b0;
    logic [7:0] last_rd = 8'h00;

    cpu_mem_responder #(
        .RAM_AW (10),
        .RD_WAIT(RD_W),
        .WR_WAIT(WR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr_bus (addr_bus),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .mem_ready(mem_ready),
        .mem_err  (mem_err),
        .busy     (busy),
        .prog_we  (prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every completion strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && mem_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ready: got ready with empty queue (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_err"}, 32'(mem_err), 32'(e.err));
                if (e.chk_rd)
                    check({e.name, "_rd"}, 32'(rd_data), 32'(e.rd));
                check({e.name, "_lat"}, 32'(cyc), 32'(e.rdy_cyc));
            end
        end
    end

    task automatic prog(input logic [7:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    // Called at a negedge. With hold set the request stays up after mem_ready so the
    // next call forms a back-to-back access sampled in the following IDLE cycle.
    task automatic do_access(input string nm, input int dir, input logic [15:0] a,
                             input logic [7:0] d, input logic [7:0] exp_rd,
                             input bit exp_err, input bit hold);
        exp_t e;
        int   lat;
        int   n;
        addr_bus  = a;
        wr_data   = d;
        mem_read  = (dir != WR);
        mem_write = (dir != RD);
        lat       = (dir == RD) ? RD_W : (dir == WR) ? WR_W : 0;
        e.name    = nm;
        e.rd      = (dir == RD) ? exp_rd : last_rd;
        e.chk_rd  = (dir != BOTH);
        e.err     = exp_err;
        e.rdy_cyc = cyc + (after_ready ? 2 : 1) + lat;
        sb.push_back(e);
        if (dir == RD)
            last_rd = exp_rd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_ready && n < 40);
        if (!mem_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: no mem_ready within 40 cycles", nm);
        end
        after_ready = 1'b1;
        if (!hold) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            @(negedge clk);
            after_ready = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset     = 1'b1;
        addr_bus  = 16'h0000;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        wr_data   = 8'h00;
        prog_we   = 1'b0;
        prog_addr = 8'h00;
        prog_data = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_rd_data", 32'(rd_data), 32'h00);
        check("rst_ready", 32'(mem_ready), 32'h0);
        check("rst_err", 32'(mem_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        prog(8'h00, 8'hA9);
        prog(8'h01, 8'h22);
        prog(8'h02, 8'h33);
        prog(8'h10, 8'h3C);

        do_access("rom_rd0",     RD,   16'h0000, 8'h00, 8'hA9, 1'b0, 1'b0);
        do_access("ram_wr100",   WR,   16'h0100, 8'h55, 8'h00, 1'b0, 1'b0);
        do_access("ram_rd100",   RD,   16'h0100, 8'h00, 8'h55, 1'b0, 1'b0);
        do_access("ram_wr4ff",   WR,   16'h04FF, 8'hC3, 8'h00, 1'b0, 1'b0);
        do_access("ram_rd4ff",   RD,   16'h04FF, 8'h00, 8'hC3, 1'b0, 1'b0);
        do_access("unm_wr500",   WR,   16'h0500, 8'h77, 8'h00, 1'b1, 1'b0);
        do_access("alias_rd100", RD,   16'h0100, 8'h00, 8'h55, 1'b0, 1'b0);
        do_access("unm_rd500",   RD,   16'h0500, 8'h00, 8'hFF, 1'b1, 1'b0);
        do_access("rom_wr10",    WR,   16'h0010, 8'h99, 8'h00, 1'b1, 1'b0);
        do_access("rom_rd10",    RD,   16'h0010, 8'h00, 8'h3C, 1'b0, 1'b0);
        do_access("illegal",     BOTH, 16'h0100, 8'hEE, 8'h00, 1'b1, 1'b0);
        do_access("post_ill_rd", RD,   16'h0100, 8'h00, 8'h55, 1'b0, 1'b0);

        // Three held reads; the ROM load lands on the commit edge of the middle one.
        do_access("b2b_rd0", RD, 16'h0000, 8'h00, 8'hA9, 1'b0, 1'b1);
        t = cyc + 2;
        fork
            do_access("b2b_rd1", RD, 16'h0001, 8'h00, 8'h22, 1'b0, 1'b1);
            begin
                while (cyc != t) @(negedge clk);
                prog_we   = 1'b1;
                prog_addr = 8'h01;
                prog_data = 8'h5A;
                @(negedge clk);
                prog_we   = 1'b0;
            end
        join
        do_access("b2b_rd2",  RD, 16'h0002, 8'h00, 8'h33, 1'b0, 1'b0);
        do_access("reread_1", RD, 16'h0001, 8'h00, 8'h5A, 1'b0, 1'b0);

        // Reset in the middle of a read's wait state.
        addr_bus = 16'h0002;
        mem_read = 1'b1;
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        check("midrst_rd_data", 32'(rd_data), 32'h00);
        check("midrst_ready", 32'(mem_ready), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        mem_read = 1'b0;
        repeat (2) @(negedge clk);
        reset       = 1'b0;
        last_rd     = 8'h00;
        after_ready = 1'b0;
        @(negedge clk);
        do_access("post_rst_rd", RD, 16'h04FF, 8'h00, 8'hC3, 1'b0, 1'b0);
        do_access("post_rst_wr", WR, 16'h0101, 8'h11, 8'h00, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

Synthesizable memory-side responder for the 8-bit CPU bus. It answers CPU reads and writes on `addr_bus`: a 256-byte program ROM at 0x0000–0x00FF and a parameter-sized RAM starting at 0x0100. Each access takes a programmable number of wait states and completes with a `mem_ready` handshake. It replaces the behavioural memory model at the top level and gives the CPU a real bus target with latency, decode and error reporting.

## Interface
- `RAM_AW`, 10: RAM address width. RAM occupies 0x0100 to 0x0100 + 2^RAM_AW − 1 (default 0x0100–0x04FF).
- `RD_WAIT`, 1: wait states per read (0–15).
- `WR_WAIT`, 0: wait states per write (0–15).
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `addr_bus`  in  16  CPU address.
- `mem_read`  in  1  read request (level).
- `mem_write`  in  1  write request (level).
- `wr_data`  in  8  CPU write data (accumulator value).
- `rd_data`  out  8  read data (registered).
- `mem_ready`  out  1  one-cycle completion strobe.
- `mem_err`  out  1  error strobe, coincident with `mem_ready`.
- `busy`  out  1  high in WAIT and DONE.
- `prog_we`  in  1  ROM load strobe.
- `prog_addr`  in  8  ROM load address.
- `prog_data`  in  8  ROM load data.

## Operation
- FSM states: IDLE, WAIT, DONE.
- **IDLE:**
  - If exactly one of `mem_read`/`mem_write` is high, latch `addr_bus`, `wr_data` and the direction, then load the wait counter with RD_WAIT or WR_WAIT.
  - Go to WAIT if the count is nonzero, otherwise to DONE.
  - If neither request is high, stay in IDLE.
- **Both requests high in IDLE:** illegal. The access is treated as erroring, with no memory effect. Go directly to DONE with `mem_err`=1.
- **WAIT:** decrement the counter each cycle. Go to DONE on the edge where the counter reaches 1.
- **Decode and commit (on the edge entering DONE, latched address):**
  - 0x0000–0x00FF: ROM. A read returns the ROM byte. A write is ignored and sets `mem_err`.
  - RAM window: a read returns the RAM byte; a write stores the latched `wr_data`.
  - Any other address is unmapped. A read returns 0xFF, a write is ignored, and `mem_err` is set.
- **DONE:** `mem_ready`=1 for exactly one cycle, then return to IDLE.
- **`rd_data` hold:** `rd_data` is updated only on reads, including reads that error. It holds its value across writes and idle cycles.
- **Request sampling:** requests are re-sampled only in IDLE. Changes to `addr_bus`/`wr_data` during WAIT/DONE have no effect.
- **ROM load port:**
  - Writes to the ROM occur on any edge where `prog_we`=1, regardless of FSM state.
  - If a ROM read commits on the same edge to the same address, the read returns the old byte.
- **Memory contents** are not cleared by reset.

## Timing
- **Reset values:** `rd_data`=0x00, `mem_ready`=0, `mem_err`=0, `busy`=0, state IDLE, counter 0.
- **Latency:** a request is first sampled high at edge E0. `mem_ready` is high in the cycle after edge E0+W, where W = wait states. With W=0, `mem_ready` is high in the cycle immediately after E0.
- **Throughput:** minimum access period is W+2 cycles (IDLE, W×WAIT, DONE).
- **Handshake:**
  - The CPU holds the request and its address/data until it samples `mem_ready`=1.
  - The CPU may present the next request immediately after `mem_ready`. That request is sampled in the following IDLE cycle.
  - If the request is still high in IDLE after DONE, it is treated as a new access.
- **Reset asserted mid-access (WAIT or DONE):** the FSM returns to IDLE asynchronously. A write not yet committed is dropped. A write already committed remains in RAM.

## Test plan
- **Reset:** assert `reset` for 2 cycles during a read in WAIT → `rd_data`=0x00, `mem_ready`=0, `busy`=0 immediately. The next read completes normally.
- **ROM read (RD_WAIT=1):** prog 0x00=0xA9, then read 0x0000 → `mem_ready` high exactly 2 cycles after the request is sampled, `rd_data`=0xA9, `mem_err`=0.
- **RAM write/read (WR_WAIT=0):** write 0x55 to 0x0100 → `mem_ready` 1 cycle after sampling. Then read 0x0100 → 0x55. `rd_data` unchanged during the write.
- **Boundary:** write and read 0x04FF → data is stored and returned. Write to 0x0500 → `mem_err`=1 and RAM is unchanged. Read 0x0500 → 0xFF with `mem_err`=1. Write to 0x0010 (ROM) → `mem_err`=1 and the ROM byte is unchanged.
- **Illegal request:** `mem_read`=`mem_write`=1 at 0x0100 → `mem_err`=1 with `mem_ready`, and RAM[0x0100] is unchanged.
- **Back-to-back and collision:** hold `mem_read` high over 3 consecutive reads of 0x0000–0x0002 → `mem_ready` every 3 cycles. Issue `prog_we` to 0x01 on the commit edge of the read of 0x0001 → that read returns the old byte, and a re-read returns the new one.
